// File: rtl/mining_node.sv
// NoC-attached Bitcoin mining element: receives a job, double-SHA256 hashes its
// nonce slice with a stride of NUM_PES, and reports FOUND/EXHAUSTED to the host.
module sha256_core (
   input  logic         clk,
   input  logic         nreset,
   input  logic         start,
   input  logic         chain,
   input  logic [511:0] block,
   output logic         blk_done,
   output logic [255:0] hash_out
);
   localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
   localparam logic [2047:0] K = {
      256'h428a2f9871374491b5c0fbcfe9b5dba53956c25b59f111f1923f82a4ab1c5ed5,
      256'hd807aa9812835b01243185be550c7dc372be5d7480deb1fe9bdc06a7c19bf174,
      256'he49b69c1efbe47860fc19dc6240ca1cc2de92c6f4a7484aa5cb0a9dc76f988da,
      256'h983e5152a831c66db00327c8bf597fc7c6e00bf3d5a7914706ca635114292967,
      256'h27b70a852e1b21384d2c6dfc53380d13650a7354766a0abb81c2c92e92722c85,
      256'ha2bfe8a1a81a664bc24b8b70c76c51a3d192e819d6990624f40e3585106aa070,
      256'h19a4c1161e376c082748774c34b0bcb5391c0cb34ed8aa4a5b9cca4f682e6ff3,
      256'h748f82ee78a5636f84c878148cc7020890befffaa4506cebbef9a3f7c67178f2};

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   logic [31:0]  v [8];
   logic [31:0]  nv [8];
   logic [31:0]  w [16];
   logic [31:0]  t1, t2, wn;
   logic [5:0]   rnd;
   logic         running;
   logic [255:0] base, sum;

   assign base = chain ? hash_out : IV;

   // One compression round per cycle; w is a sliding 16-word schedule window.
   always_comb begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[{~rnd, 5'b0} +: 32] + w[0];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      nv[0] = t1 + t2;
      nv[1] = v[0];
      nv[2] = v[1];
      nv[3] = v[2];
      nv[4] = v[3] + t1;
      nv[5] = v[4];
      nv[6] = v[5];
      nv[7] = v[6];
      wn = (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9]
         + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];
      sum = '0;
      for (int i = 0; i < 8; i++) sum[255 - 32*i -: 32] = hash_out[255 - 32*i -: 32] + nv[i];
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         running  <= 1'b0;
         rnd      <= '0;
         blk_done <= 1'b0;
         hash_out <= '0;
      end else begin
         blk_done <= 1'b0;
         if (start) begin
            hash_out <= base;
            for (int i = 0; i < 8; i++) v[i] <= base[255 - 32*i -: 32];
            for (int i = 0; i < 16; i++) w[i] <= block[511 - 32*i -: 32];
            running <= 1'b1;
            rnd     <= '0;
         end else if (running) begin
            for (int i = 0; i < 8; i++) v[i] <= nv[i];
            for (int i = 0; i < 15; i++) w[i] <= w[i+1];
            w[15] <= wn;
            rnd   <= rnd + 6'd1;
            if (rnd == 6'd63) begin
               running  <= 1'b0;
               blk_done <= 1'b1;
               hash_out <= sum;
            end
         end
      end
   end
endmodule

module mining_node #(
   parameter int FLIT_DATA_WIDTH = 64,
   parameter int DEST_BITS       = 5,
   parameter int VC_BITS         = 2,
   parameter int NUM_PES         = 4,
   parameter int HOST_ID         = 0,
   parameter int OUT_CREDITS     = 4
) (
   input  logic                                       sys_clk,
   input  logic                                       reset,
   input  logic [DEST_BITS-1:0]                       processor_id,
   input  logic [FLIT_DATA_WIDTH+DEST_BITS+VC_BITS+1:0] flit,
   output logic                                       send_credit,
   output logic [VC_BITS:0]                           credit_in,
   output logic                                       EN_putFlit,
   output logic [FLIT_DATA_WIDTH+DEST_BITS+VC_BITS+1:0] putFlit,
   input  logic [VC_BITS:0]                           out_credit,
   output logic                                       busy
);
   localparam int FW = FLIT_DATA_WIDTH + DEST_BITS + VC_BITS + 2;
   localparam int CW = (OUT_CREDITS < 2) ? 1 : $clog2(OUT_CREDITS + 1);
   localparam logic [2:0] S_IDLE = 3'd0, S_RX_HDR = 3'd1, S_PAD = 3'd2, S_BLK1 = 3'd3,
                          S_BLK2 = 3'd4, S_BLK3 = 3'd5, S_CHECK = 3'd6, S_TX = 3'd7;

   logic [2:0]     state;
   logic [639:0]   hdr;
   logic [3:0]     hdr_cnt;
   logic [31:0]    nonce, nonce_next;
   logic [7:0]     zero_bits, status;
   logic [63:0]    cycles, tx_data;
   logic [1:0]     tx_idx;
   logic [CW-1:0]  credits;
   logic           issued, pkt_start, carry, found, in_search, is_cmd, abort, start, blk_done;
   logic [255:0]   hash_out, mask;
   logic [511:0]   block;
   logic [1023:0]  msg;
   logic           f_valid, f_tail;
   logic [VC_BITS-1:0] f_vc;
   logic [63:0]    f_data;
   logic           unused_bits;

   assign f_valid     = flit[FW-1];
   assign f_tail      = flit[FW-2];
   assign f_vc        = flit[FLIT_DATA_WIDTH +: VC_BITS];
   assign f_data      = flit[63:0];
   assign unused_bits = ^{flit[FLIT_DATA_WIDTH+VC_BITS +: DEST_BITS], out_credit[VC_BITS-1:0]};

   // A flit is a command only when it opens a packet; header payloads never alias one.
   assign in_search = (state >= S_RX_HDR) && (state <= S_CHECK);
   assign is_cmd    = f_valid && pkt_start;
   assign abort     = is_cmd && f_tail && (f_data[63:56] == 8'h02) && in_search;
   assign start     = (state >= S_BLK1) && (state <= S_BLK3) && !issued && !abort;
   assign busy      = (state != S_IDLE);

   assign msg   = {hdr[639:32], nonce, 1'b1, 319'b0, 64'h280};
   assign block = (state == S_BLK1) ? msg[1023:512] :
                  (state == S_BLK2) ? msg[511:0] : {hash_out, 1'b1, 191'b0, 64'h100};
   assign mask  = ~({256{1'b1}} >> zero_bits);
   assign found = ((hash_out & mask) == '0);
   assign {carry, nonce_next} = {1'b0, nonce} + 33'(NUM_PES);

   sha256_core u_sha (
      .clk(sys_clk), .nreset(~reset), .start(start), .chain(state == S_BLK2),
      .block(block), .blk_done(blk_done), .hash_out(hash_out)
   );

   always_comb begin
      case (tx_idx)
         2'd0:    tx_data = {status, 24'h0, {(32-DEST_BITS){1'b0}}, processor_id};
         2'd1:    tx_data = {32'h0, nonce};
         default: tx_data = cycles;
      endcase
      EN_putFlit = (state == S_TX) && (credits != '0);
      putFlit    = EN_putFlit ? {1'b1, tx_idx == 2'd2, DEST_BITS'(HOST_ID), {VC_BITS{1'b0}}, tx_data} : '0;
   end

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         credits <= CW'(OUT_CREDITS);
      end else if (EN_putFlit && !out_credit[VC_BITS]) begin
         credits <= credits - 1'b1;
      end else if (!EN_putFlit && out_credit[VC_BITS] && credits < CW'(OUT_CREDITS)) begin
         credits <= credits + 1'b1;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         state       <= S_IDLE;
         send_credit <= 1'b0;
         credit_in   <= '0;
         pkt_start   <= 1'b1;
         issued      <= 1'b0;
         cycles      <= '0;
         hdr         <= '0;
         hdr_cnt     <= '0;
         nonce       <= '0;
         zero_bits   <= '0;
         status      <= '0;
         tx_idx      <= '0;
      end else begin
         send_credit <= f_valid;
         credit_in   <= {f_valid, f_valid ? f_vc : {VC_BITS{1'b0}}};
         if (f_valid) pkt_start <= f_tail;
         if (in_search && cycles != '1) cycles <= cycles + 64'd1;
         if (abort) begin
            state  <= S_IDLE;
            issued <= 1'b0;
         end else begin
            case (state)
               S_IDLE: if (is_cmd && f_data[63:56] == 8'h01) begin
                  zero_bits <= f_data[7:0];
                  nonce     <= f_data[39:8] + 32'(processor_id) - 32'd1;
                  cycles    <= '0;
                  hdr_cnt   <= '0;
                  state     <= S_RX_HDR;
               end
               S_RX_HDR: if (f_valid) begin
                  hdr     <= {hdr[575:0], f_data};
                  hdr_cnt <= hdr_cnt + 4'd1;
                  if (hdr_cnt == 4'd9) state <= S_PAD;
               end
               S_PAD: state <= S_BLK1;
               S_BLK1, S_BLK2, S_BLK3: begin
                  if (!issued) issued <= 1'b1;
                  else if (blk_done) begin
                     issued <= 1'b0;
                     state  <= state + 3'd1;
                  end
               end
               S_CHECK: begin
                  tx_idx <= '0;
                  if (found) begin
                     status <= 8'h01;
                     state  <= S_TX;
                  end else if (carry) begin
                     status <= 8'h02;
                     state  <= S_TX;
                  end else begin
                     nonce <= nonce_next;
                     state <= S_PAD;
                  end
               end
               default: if (EN_putFlit) begin
                  tx_idx <= tx_idx + 2'd1;
                  if (tx_idx == 2'd2) state <= S_IDLE;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_mining_node.sv
// Randomized bench for mining_node: a double-SHA256 reference model predicts each
// job's result packet, and a router model returns output credits after a delay.
module tb_mining_node;
   localparam int NP = 4;
   localparam int OC = 1;
   localparam int HOST = 0;
   localparam int ATTEMPT = 200;
   localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   logic        clock = 1'b0;
   logic        reset;
   logic [4:0]  procId;
   logic [72:0] flit;
   logic        send_credit;
   logic [2:0]  credit_in;
   logic        EN_putFlit;
   logic [72:0] putFlit;
   logic [2:0]  out_credit;
   logic        busy;

   typedef struct {
      logic [72:0] f;
      int          at;
   } rxT;

   rxT   rxQ[$];
   int   retQ[$];
   int   total = 0, bad = 0, cyc = 0;
   int   creditDelay = 3, creditsSeen = 0, outstanding = 0;
   logic lastValid = 1'b0;
   logic [1:0] lastVc = 2'b0;

   mining_node #(.NUM_PES(NP), .HOST_ID(HOST), .OUT_CREDITS(OC)) dut (
      .sys_clk(clock), .reset(reset), .processor_id(procId), .flit(flit),
      .send_credit(send_credit), .credit_in(credit_in), .EN_putFlit(EN_putFlit),
      .putFlit(putFlit), .out_credit(out_credit), .busy(busy)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] shaBlock(input logic [255:0] hin, input logic [511:0] blk);
      logic [31:0] w [64];
      logic [31:0] v [8];
      logic [31:0] t1, t2;
      logic [255:0] r;
      for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
      for (int t = 16; t < 64; t++)
         w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
              + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
      for (int t = 0; t < 64; t++) begin
         t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
         t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         for (int i = 7; i > 0; i--) v[i] = v[i-1];
         v[4] = v[4] + t1;
         v[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
      return r;
   endfunction

   // SHA256(SHA256(80-byte header with the nonce in its last word)).
   function automatic logic [255:0] doubleSha(input logic [639:0] hdr, input logic [31:0] nonce);
      logic [639:0] h80;
      logic [255:0] h1;
      h80 = {hdr[639:32], nonce};
      h1  = shaBlock(IV, h80[639:128]);
      h1  = shaBlock(h1, {h80[127:0], 1'b1, 319'b0, 64'd640});
      return shaBlock(IV, {h1, 1'b1, 191'b0, 64'd256});
   endfunction

   task automatic runModel(input logic [639:0] hdr, input logic [31:0] base, input int zb, input int pid,
                           output logic [7:0] st, output logic [31:0] nonce, output int attempts);
      logic [255:0] h;
      longint n;
      n = (longint'(base) + pid - 1) & 64'hFFFFFFFF;
      attempts = 0;
      forever begin
         attempts++;
         h = doubleSha(hdr, n[31:0]);
         if (zb == 0 || (h >> (256 - zb)) == 0) begin st = 8'h01; break; end
         if (n + NP > 64'hFFFFFFFF) begin st = 8'h02; break; end
         n = n + NP;
      end
      nonce = n[31:0];
   endtask

   // Monitor and router model, sampled 2 time units after the falling edge.
   initial begin
      out_credit = '0;
      forever begin
         @(negedge clock);
         #2;
         if (retQ.size() > 0 && retQ[0] <= cyc) begin
            out_credit = 3'b100;
            void'(retQ.pop_front());
            outstanding--;
         end else out_credit = '0;
         if (!reset) begin
            if (lastValid || send_credit)
               checkOutput("creditRet", {60'h0, send_credit, credit_in}, {60'h0, lastValid, lastValid, lastVc});
            if (send_credit) creditsSeen++;
            if (EN_putFlit) begin
               rxQ.push_back('{putFlit, cyc});
               retQ.push_back(cyc + creditDelay);
               outstanding++;
               checkOutput("creditGate", 64'(outstanding <= OC), 64'd1);
            end
         end
         lastValid = flit[72];
         lastVc    = flit[65:64];
      end
   end

   task automatic resetDut(input logic [4:0] pid);
      reset  = 1'b1;
      flit   = '0;
      procId = pid;
      repeat (3) @(negedge clock);
      rxQ.delete();
      retQ.delete();
      outstanding = 0;
      reset = 1'b0;
   endtask

   task automatic applyStimulus(input logic tail, input logic [63:0] data);
      @(negedge clock);
      flit = {1'b1, tail, procId, 2'($urandom_range(0, 3)), data};
   endtask

   task automatic idleLine();
      @(negedge clock);
      flit = '0;
   endtask

   task automatic sendJob(input logic [639:0] hdr, input logic [31:0] base, input logic [7:0] zb, input logic expBusy);
      applyStimulus(1'b0, {8'h01, 16'($urandom), base, zb});
      for (int i = 0; i < 10; i++) begin
         applyStimulus(i == 9, hdr[639 - 64*i -: 64]);
         if (i == 0) checkOutput("busyRise", 64'(busy), 64'(expBusy));
      end
      idleLine();
   endtask

   task automatic expectResult(input logic [7:0] st, input logic [31:0] nonce, input int attempts);
      int n = 0;
      while (rxQ.size() < 3 && n < 10 + attempts * ATTEMPT + 400) begin
         @(negedge clock);
         n++;
      end
      #3;
      if (rxQ.size() < 3) checkOutput("resultTimeout", 64'(rxQ.size()), 64'd3);
      else begin
         checkOutput("flit0Data", rxQ[0].f[63:0], {st, 24'h0, 27'h0, procId});
         checkOutput("flit1Data", rxQ[1].f[63:0], {32'h0, nonce});
         checkOutput("flit2Cycles", rxQ[2].f[63:0], 64'(10 + attempts * ATTEMPT));
         for (int i = 0; i < 3; i++)
            checkOutput("flitHdr", 64'(rxQ[i].f[72:64]), 64'({1'b1, i == 2, 5'(HOST), 2'b0}));
         checkOutput("gap01", 64'(rxQ[1].at - rxQ[0].at), 64'(creditDelay + 1));
         checkOutput("gap12", 64'(rxQ[2].at - rxQ[1].at), 64'(creditDelay + 1));
         rxQ.delete();
      end
      @(negedge clock);
      checkOutput("busyFall", 64'(busy), 64'd0);
   endtask

   task automatic randomHeader(output logic [639:0] hdr);
      for (int i = 0; i < 20; i++) hdr[32*i +: 32] = $urandom;
   endtask

   task automatic checkJob(input logic [639:0] hdr, input logic [31:0] base, input logic [7:0] zb);
      logic [7:0] st;
      logic [31:0] nonce;
      int att;
      runModel(hdr, base, zb, procId, st, nonce, att);
      creditsSeen = 0;
      sendJob(hdr, base, zb, 1'b1);
      expectResult(st, nonce, att);
      checkOutput("credits11", 64'(creditsSeen), 64'd11);
   endtask

   initial begin
      logic [639:0] hdr, hdrB;
      logic [7:0] st;
      logic [31:0] nonce;
      int att;
      flit = '0;
      resetDut(5'd1);
      #3;
      checkOutput("rstEn", 64'(EN_putFlit), 64'd0);
      checkOutput("rstPut", 64'(|putFlit), 64'd0);
      checkOutput("rstCredit", {61'h0, send_credit, credit_in[2:1]}, 64'd0);
      checkOutput("rstBusy", 64'(busy), 64'd0);

      randomHeader(hdr);
      checkJob(hdr, 32'h9546A142, 8'd0);

      for (int j = 0; j < 3; j++) begin
         resetDut(5'($urandom_range(1, NP)));
         randomHeader(hdr);
         checkJob(hdr, $urandom, 8'($urandom_range(1, 3)));
      end

      resetDut(5'd2);
      randomHeader(hdr);
      checkJob(hdr, 32'hFFFFFFFC, 8'd255);

      // Abort while the second compression block is running.
      resetDut(5'd1);
      randomHeader(hdr);
      sendJob(hdr, 32'h100, 8'd255, 1'b1);
      repeat (97) @(negedge clock);
      applyStimulus(1'b1, {8'h02, 56'h0});
      idleLine();
      checkOutput("abortBusy", 64'(busy), 64'd0);
      repeat (300) @(negedge clock);
      checkOutput("abortNoOut", 64'(rxQ.size()), 64'd0);
      randomHeader(hdr);
      checkJob(hdr, $urandom, 8'd0);

      creditDelay = 20;
      randomHeader(hdr);
      checkJob(hdr, $urandom, 8'd0);
      creditDelay = 3;

      // A second job arriving while busy is credited and dropped.
      randomHeader(hdr);
      randomHeader(hdrB);
      runModel(hdr, 32'h1234, 8'd2, procId, st, nonce, att);
      creditsSeen = 0;
      sendJob(hdr, 32'h1234, 8'd2, 1'b1);
      repeat (20) @(negedge clock);
      sendJob(hdrB, 32'h0, 8'd0, 1'b1);
      expectResult(st, nonce, att);
      checkOutput("credits22", 64'(creditsSeen), 64'd22);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mining_node.md
# mining_node

NoC-attached Bitcoin mining processing element, second generation. Receives job packets from the host over the CONNECT network and searches a host-assigned nonce range with an interleaved stride across `NUM_PES` nodes. Hashing uses the team's `SHA256` core, with the difficulty carried in each job. Results go back to the host under credit-based flow control, and a running search can be aborted by a host message.

## Interface
- `FLIT_DATA_WIDTH`, 64: flit payload bits; fixed at 64 in this generation.
- `DEST_BITS`, 5: destination field width.
- `VC_BITS`, 2: virtual-channel field width.
- `NUM_PES`, 4: nonce stride (node count); 1..31.
- `HOST_ID`, 0: destination of result packets.
- `OUT_CREDITS`, 4: initial output credit count (router input buffer depth).
- `sys_clk` in 1: clock.
- `reset` in 1: synchronous, active-high. Internally `SHA256.nreset = ~reset`.
- `processor_id` in DEST_BITS: node id, 1..NUM_PES; static.
- `flit` in 73: {valid, tail, dest, vc, data}; ejected flit.
- `send_credit` out 1: credit return strobe.
- `credit_in` out 1+VC_BITS: {valid, vc} of the returned credit.
- `EN_putFlit` out 1: inject strobe.
- `putFlit` out 73: injected flit.
- `out_credit` in 1+VC_BITS: {valid, vc} credit from the router.
- `busy` out 1: high from job accept until the result flit 2 is sent or an abort occurs.

## Operation
- Command word (flit 0 data):
  - [63:56] opcode: 0x01 JOB, 0x02 ABORT.
  - [39:8] nonce_base.
  - [7:0] zero_bits.
- JOB is 11 flits: command plus 10 header flits, tail on the last.
- ABORT is 1 flit, tail set.
- Every valid input flit is consumed. The next cycle drives `send_credit=1`, `credit_in={1'b1, flit.vc}`. Otherwise both are 0.
- States: IDLE, RX_HDR, PAD, BLK1, BLK2, BLK3, CHECK, TX.
- IDLE, on valid JOB command:
  - latch zero_bits.
  - nonce ← nonce_base + processor_id − 1 (mod 2^32).
  - clear cycle counter.
  - hdr_cnt ← 0; go to RX_HDR.
  - Any other opcode is dropped.
- RX_HDR:
  - header flit i is written to hdr[639−64i −: 64] (first flit most significant).
  - after 10 flits go to PAD.
  - a non-tail 10th flit or an early tail is not an error; the count alone governs.
- PAD: build {hdr[639:32], nonce, 1'b1, 319'b0, 64'h280} (1024 bits).
- BLK1: present bits [1023:512] with blk_type=HEADER, pulse `start`, wait for `blk_done`.
- BLK2: present bits [511:0], pulse `start`, wait for `blk_done`.
- BLK3: present {hash_out, 1'b1, 191'b0, 64'h100} with blk_type=HASH, pulse `start`, wait for `blk_done`.
- CHECK, success condition: hash_out[255 −: zero_bits] == 0. zero_bits=0 always succeeds; zero_bits ≥ 256 is clamped to 256.
- CHECK outcomes:
  - success → TX with FOUND (0x01).
  - else, if nonce + NUM_PES carries out of 32 bits → TX with EXHAUSTED (0x02).
  - else nonce += NUM_PES → PAD. Header is retained; no re-receive.
- ABORT received in RX_HDR..CHECK: the cycle it is seen, deassert `start`, discard the job, go to IDLE, no result. An in-flight SHA256 result is ignored.
- ABORT received in TX or IDLE: consumed and ignored.
- JOB command received while not in IDLE: its flits are consumed and dropped until its tail.
- Result packet, dest=HOST_ID, vc=0:
  - flit 0 data {status[7:0], 24'h0, 27'h0, processor_id}.
  - flit 1 data {32'h0, nonce}.
  - flit 2 data cycle count, tail=1.
  - After flit 2, go to IDLE.
- Cycle counter: 64-bit; increments every cycle in RX_HDR..CHECK; saturates at all ones; holds otherwise.
- Output credits:
  - counter init OUT_CREDITS, max OUT_CREDITS.
  - a flit is injected only when credits > 0; injection decrements.
  - each valid `out_credit` increments.
  - simultaneous inject and return leaves the count unchanged.

## Timing
- Reset values:
  - `EN_putFlit`=0, `putFlit`=0, `send_credit`=0, `credit_in`=0, `busy`=0.
  - state IDLE, credits=OUT_CREDITS, counter=0, `start`=0.
- Reset mid-operation returns to IDLE in one cycle. Any flit present that cycle is not credited.
- `start` is a single-cycle pulse per block.
- Credit return is 1 cycle after flit acceptance.
- `busy` rises the cycle after the JOB command is accepted.
- TX:
  - `EN_putFlit` is a 1-cycle strobe per flit with `putFlit` valid the same cycle.
  - no more than one flit per cycle.
  - back-to-back injection is allowed while credits last.
  - with credits = 0, TX stalls with `EN_putFlit`=0.
  - `putFlit` returns to 0 when not injecting.
- CHECK takes exactly 1 cycle; PAD takes 1 cycle.

## Test plan
- NUM_PES=4, processor_id=1, JOB with a known header where nonce_base puts 0x9546A142 at this node, zero_bits=32 → FOUND packet with flit1 data=0x9546A142, tail on flit 2 only, 11 credits returned.
- zero_bits=0, any header → FOUND on the first nonce; cycle count equals the RX_HDR..CHECK cycles of a single attempt.
- nonce_base=0xFFFFFFFC, processor_id=2, NUM_PES=4, unreachable target (zero_bits=255) → exactly one attempt at 0xFFFFFFFD, then EXHAUSTED with nonce 0xFFFFFFFD.
- ABORT injected mid-BLK2 → no output flits, `busy` falls, a next JOB is accepted and completes normally.
- OUT_CREDITS=1, router withholds credits for 20 cycles after flit 0 → flit 1 is not injected until the `out_credit` pulse, then flits 1 and 2 follow with credit gating.
- Second JOB sent while busy → its 11 flits are credited and dropped; the first job's result is unaffected.
